// File: rtl/reg_file_wb_if.sv
// ALU -> register file write channel. The ALU drives data/addr/valid
// and the register file answers with a single-cycle ack.
interface reg_file_wb_if;
  logic [31:0] reg_wr_data;
  logic [4:0]  reg_wr_addr;
  logic        reg_wr_data_valid;
  logic        reg_wr_ack;

  modport master (
    output reg_wr_data,
    output reg_wr_addr,
    output reg_wr_data_valid,
    input  reg_wr_ack
  );

  modport slave (
    input  reg_wr_data,
    input  reg_wr_addr,
    input  reg_wr_data_valid,
    output reg_wr_ack
  );
endinterface

// File: rtl/reg_file_wb.sv
// Integer register file with a write-back responder: accepts one ALU write
// at a time, commits it after ACK_LATENCY wait states and pulses an ack.
module reg_file_wb #(
  parameter int ACK_LATENCY = 0,
  parameter int NUM_REGS    = 32
) (
  input  logic              clk,
  input  logic              reset,
  reg_file_wb_if.slave      wr,
  input  logic [4:0]        rs1_addr,
  output logic [31:0]       rs1_data,
  input  logic [4:0]        rs2_addr,
  output logic [31:0]       rs2_data,
  output logic              busy,
  output logic [31:0]       wr_count
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        ack_next, busy_next;
  logic        capture, commit;
  logic [4:0]  cap_addr, commit_addr;
  logic [31:0] cap_data, commit_data;
  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      wr.reg_wr_ack <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      wr.reg_wr_ack <= ack_next;
      busy          <= busy_next;
    end
  end

  // ACK is a one-cycle guard state so a still-held valid cannot re-commit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ack_next   = 1'b0;
    busy_next  = busy;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (wr.reg_wr_data_valid && !wr.reg_wr_ack) begin
          capture = 1'b1;
          if (ACK_LATENCY == 0) begin
            commit     = 1'b1;
            ack_next   = 1'b1;
            state_next = ACK;
          end else begin
            cnt_next   = 4'(ACK_LATENCY);
            busy_next  = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit     = 1'b1;
          ack_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the commit happens on the accept edge, straight from the bus.
  assign commit_addr = (state == IDLE) ? wr.reg_wr_addr : cap_addr;
  assign commit_data = (state == IDLE) ? wr.reg_wr_data : cap_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_addr <= '0;
      cap_data <= '0;
    end else if (capture) begin
      cap_addr <= wr.reg_wr_addr;
      cap_data <= wr.reg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      if (commit_addr != 5'd0 && int'(commit_addr) < NUM_REGS)
        regs[commit_addr] <= commit_data;
      wr_count <= wr_count + 32'd1;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0 || int'(rs1_addr) >= NUM_REGS) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0 || int'(rs2_addr) >= NUM_REGS) ? '0 : regs[rs2_addr];

endmodule

// File: tb/tb_reg_file_wb.sv
// Checks reg_file_wb at ACK_LATENCY 0 and 3 against an array-based model
// of the register contents, commit count and ack/busy timing.
module tb_reg_file_wb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_file_wb_if if0 ();
  reg_file_wb_if if3 ();

  logic        sel = 1'b0;
  logic        tb_valid = 1'b0;
  logic [4:0]  tb_addr = '0;
  logic [31:0] tb_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_d0, rs2_d0, rs1_d3, rs2_d3, cnt0, cnt3;
  logic        busy0, busy3;

  assign if0.reg_wr_data       = tb_data;
  assign if0.reg_wr_addr       = tb_addr;
  assign if0.reg_wr_data_valid = tb_valid & ~sel;
  assign if3.reg_wr_data       = tb_data;
  assign if3.reg_wr_addr       = tb_addr;
  assign if3.reg_wr_data_valid = tb_valid & sel;

  reg_file_wb #(.ACK_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr(if0),
    .rs1_addr(rs1_addr), .rs1_data(rs1_d0),
    .rs2_addr(rs2_addr), .rs2_data(rs2_d0),
    .busy(busy0), .wr_count(cnt0)
  );

  reg_file_wb #(.ACK_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .wr(if3),
    .rs1_addr(rs1_addr), .rs1_data(rs1_d3),
    .rs2_addr(rs2_addr), .rs2_data(rs2_d3),
    .busy(busy3), .wr_count(cnt3)
  );

  wire        ack_o  = sel ? if3.reg_wr_ack : if0.reg_wr_ack;
  wire        busy_o = sel ? busy3 : busy0;
  wire [31:0] rs1_o  = sel ? rs1_d3 : rs1_d0;
  wire [31:0] rs2_o  = sel ? rs2_d3 : rs2_d0;
  wire [31:0] cnt_o  = sel ? cnt3 : cnt0;

  logic [31:0] mregs [2][32];
  logic [31:0] mcount [2];
  int n_cmp = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 32; r++) mregs[s][r] = '0;
      mcount[s] = '0;
    end
  endtask

  // One write; k counts edges after the accept edge, commit lands on edge k==lat.
  task automatic applyStimulus(input logic s, input logic [4:0] a, input logic [31:0] d, input bit drop);
    int lat;
    logic [31:0] oldv, newv;
    lat  = s ? 3 : 0;
    oldv = mregs[s][a];
    newv = (a == 5'd0) ? 32'd0 : d;
    @(negedge clk);
    sel = s; tb_addr = a; tb_data = d; tb_valid = 1'b1;
    rs1_addr = a; rs2_addr = a;
    @(posedge clk); #1;
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      checkOutput("ack",  32'(ack_o),  32'(k == lat));
      checkOutput("busy", 32'(busy_o), 32'(k < lat));
      checkOutput("rs1",  rs1_o, (k < lat) ? oldv : newv);
      checkOutput("rs2",  rs2_o, (k < lat) ? oldv : newv);
      checkOutput("wr_count", cnt_o, (k < lat) ? mcount[s] : mcount[s] + 32'd1);
      if (drop && k == 0) begin
        @(negedge clk);
        tb_valid = 1'b0;
      end
    end
    mregs[s][a] = newv;
    mcount[s]   = mcount[s] + 32'd1;
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  initial begin
    clearModel();
    $display("[TB] reset check");
    repeat (3) @(posedge clk);
    #1;
    rs1_addr = 5'd5;
    #1;
    checkOutput("rst_ack0",  32'(if0.reg_wr_ack), 32'd0);
    checkOutput("rst_ack3",  32'(if3.reg_wr_ack), 32'd0);
    checkOutput("rst_busy0", 32'(busy0), 32'd0);
    checkOutput("rst_busy3", 32'(busy3), 32'd0);
    checkOutput("rst_cnt0",  cnt0, 32'd0);
    checkOutput("rst_cnt3",  cnt3, 32'd0);
    checkOutput("rst_rs1_0", rs1_d0, 32'd0);
    checkOutput("rst_rs1_3", rs1_d3, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed writes");
    applyStimulus(1'b0, 5'd5, 32'h2, 1'b0);
    applyStimulus(1'b1, 5'd7, 32'h4, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 5'd12, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(1'b0, 5'd31, 32'h1234_5678, 1'b1);

    $display("[TB] random writes");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during WAIT");
    @(negedge clk);
    sel = 1'b1; tb_addr = 5'd9; tb_data = 32'hCAFE_0009; tb_valid = 1'b1;
    rs1_addr = 5'd9; rs2_addr = 5'd12;
    @(posedge clk); #1;
    checkOutput("wait_busy", 32'(busy3), 32'd1);
    @(negedge clk);
    reset = 1'b1; tb_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_busy", 32'(busy3), 32'd0);
    checkOutput("mid_rst_ack",  32'(if3.reg_wr_ack), 32'd0);
    checkOutput("mid_rst_cnt",  cnt3, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clearModel();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_ack", 32'(if3.reg_wr_ack), 32'd0);
      checkOutput("post_rst_rs1", rs1_d3, 32'd0);
      checkOutput("post_rst_rs2", rs2_d3, 32'd0);
      checkOutput("post_rst_cnt", cnt3, 32'd0);
    end
    applyStimulus(1'b1, 5'd9, 32'h0000_0099, 1'b0);
    applyStimulus(1'b0, 5'd9, 32'h0000_0042, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
